nuevo_driver_7seg: RTL and testbench



---
 rtl/nuevo_driver_7seg.sv | 222 ++++++++++++++++++++++
 tb/tb_nuevo_driver_7seg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nuevo_driver_7seg.sv
// nuevo_driver_7seg
// Drives an 8-digit, common-anode, multiplexed 7-segment display from an
// N-bit unsigned value. The value is shown either in hexadecimal or in
// unsigned decimal. The decimal digits come from a free-running sequential
// double-dabble converter.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        asynchronous, active-low reset
//   DEC_TRIGGER  display mode: 1 = decimal (leading-zero blanked), 0 = hex
//   BIN_IN       unsigned value to display (N bits, 4..32)
//   CATODOS      segments {g..a}, active-low
//   ANODOS       digit enables, active-low, bit k = digit k (0 = LSD)
//
// Timing: each digit slot lasts 2^SCAN_BITS clocks. The anode/segment pair
// for a slot is loaded on the first clock of that slot. A mode change
// therefore shows up cleanly at the next slot boundary.
module nuevo_driver_7seg #(
  parameter int N         = 32,
  parameter int SCAN_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         DEC_TRIGGER,
  input  logic [N-1:0] BIN_IN,
  output logic [6:0]   CATODOS,
  output logic [7:0]   ANODOS
);

  // ---------------------------------------------------------------------
  // Binary-to-BCD converter FSM (IDLE -> SHIFT x N -> DONE -> IDLE)
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [5:0]   iter_q;
  logic [N-1:0] shift_q;
  logic [39:0]  scratch_q;
  logic [39:0]  scratch_adj;
  logic [31:0]  bcd_q;
  logic         load_en, step_en, commit_en;
  logic         last_iter;

  assign last_iter = (iter_q == 6'(N - 1));

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes
  always_comb begin
    load_en   = 1'b0;
    step_en   = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      IDLE:    load_en   = 1'b1;
      SHIFT:   step_en   = 1'b1;
      DONE:    commit_en = 1'b1;
      default: ;
    endcase
  end

  // Add-3 correction on every scratch digit that is 5 or more, so that
  // the following left shift carries correctly into the next decade.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_add3
      assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                      ? scratch_q[4*gi +: 4] + 4'd3
                                      : scratch_q[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
    end else begin
      if (load_en) begin
        shift_q   <= BIN_IN;
        scratch_q <= '0;
        iter_q    <= '0;
      end
      if (step_en) begin
        {scratch_q, shift_q} <= {scratch_adj, shift_q} << 1;
        iter_q               <= iter_q + 6'd1;
      end
      // Only the low 8 decades are kept; larger values wrap modulo 10^8.
      if (commit_en) begin
        bcd_q <= scratch_q[31:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Hex digit register (digits above the input width read as zero)
  // ---------------------------------------------------------------------
  logic [31:0] hex_d, hex_q;

  always_comb begin
    hex_d          = '0;
    hex_d[N-1:0]   = BIN_IN;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hex_q <= '0;
    end else begin
      hex_q <= hex_d;
    end
  end

  // ---------------------------------------------------------------------
  // Refresh prescaler and digit index
  // ---------------------------------------------------------------------
  logic [SCAN_BITS-1:0] presc_q;
  logic [2:0]           idx_q;
  logic                 slot_start, slot_end;

  assign slot_start = (presc_q == '0);
  assign slot_end   = &presc_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_q + SCAN_BITS'(1);
      if (slot_end) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Digit selection, blanking and segment decode
  // ---------------------------------------------------------------------
  // upper_zero[k]: BCD digits k..7 are all zero.
  logic [7:0] upper_zero;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_upper_zero
      assign upper_zero[gi] = (bcd_q[31:4*gi] == '0);
    end
  endgenerate

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [3:0] nibble;
  logic       blank;
  logic [7:0] an_d, an_q;
  logic [6:0] cat_d, cat_q;

  always_comb begin
    if (DEC_TRIGGER) begin
      nibble = bcd_q[{idx_q, 2'b00} +: 4];
    end else begin
      nibble = hex_q[{idx_q, 2'b00} +: 4];
    end
    // Digit 0 always shows, so a zero value still displays "0".
    blank = DEC_TRIGGER && (idx_q != 3'd0) && upper_zero[idx_q];
    an_d  = blank ? 8'hFF : ~(8'h01 << idx_q);
    cat_d = blank ? 7'h7F : seg7(nibble);
  end

  // Anode and segments load together, once per slot.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      an_q  <= 8'hFF;
      cat_q <= 7'h7F;
    end else if (slot_start) begin
      an_q  <= an_d;
      cat_q <= cat_d;
    end
  end

  assign ANODOS  = an_q;
  assign CATODOS = cat_q;

endmodule

// File: tb/tb_nuevo_driver_7seg.sv
// Self-checking bench for nuevo_driver_7seg (N=32, SCAN_BITS=3).
// A behavioural model predicts, for every digit slot, which anode must be
// lit and which segment pattern must show. It uses plain decimal/hex
// arithmetic on the value that is being displayed. A compare process checks
// the DUT against the model on every falling clock edge where the
// prediction is defined. Directed slot checks against hand-computed
// literals pin both the DUT and the model.
module tb_nuevo_driver_7seg;

  localparam int N    = 32;
  localparam int SLOT = 8;  // 2^SCAN_BITS clocks per digit

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         DEC_TRIGGER = 1'b0;
  logic [N-1:0] BIN_IN = '0;
  logic [6:0]   CATODOS;
  logic [7:0]   ANODOS;

  bit clk_en = 1'b0;
  bit chk_en = 1'b0;
  int checks = 0;
  int errors = 0;

  nuevo_driver_7seg #(.N(N), .SCAN_BITS(3)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DEC_TRIGGER (DEC_TRIGGER),
    .BIN_IN      (BIN_IN),
    .CATODOS     (CATODOS),
    .ANODOS      (ANODOS)
  );

  always #5 if (clk_en) CLK = ~CLK;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic longint unsigned pow10(input int k);
    longint unsigned p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // ------------------------------------------------------------------
  // Behavioural model
  //  - slot s begins on the (8s+1)-th rising edge after reset release
  //    and shows digit s mod 8;
  //  - hex: the value must have been on BIN_IN for >= 2 edges;
  //  - decimal: the value must have been stable for >= 2*(N+2)+1 edges.
  //    Slots that start within the first N+2 edges after reset show the
  //    cleared result (value 0).
  // ------------------------------------------------------------------
  int unsigned  edge_n    = 0;
  int unsigned  age       = 0;
  logic [N-1:0] last_bin  = '0;
  logic [7:0]   exp_an    = 8'hFF;
  logic [6:0]   exp_cat   = 7'h7F;
  bit           exp_valid = 1'b1;
  int           cur_digit = -1;

  always @(posedge CLK or negedge RESET) begin
    int unsigned     e, a, k;
    longint unsigned v, vm;
    int              d;
    bit              blank, valid;
    logic [7:0]      one_hot;
    if (!RESET) begin
      edge_n    <= 0;
      age       <= 0;
      exp_an    <= 8'hFF;
      exp_cat   <= 7'h7F;
      exp_valid <= 1'b1;
      cur_digit <= -1;
    end else begin
      e = edge_n + 1;
      a = (e > 1 && BIN_IN == last_bin) ? age + 1 : 1;
      edge_n   <= e;
      age      <= a;
      last_bin <= BIN_IN;
      if ((e - 1) % SLOT == 0) begin
        k       = ((e - 1) / SLOT) % 8;
        one_hot = 8'h01 << k;
        if (DEC_TRIGGER) begin
          valid = 1'b1;
          v     = 0;
          if (e <= N + 2)                v = 0;
          else if (a >= 2 * (N + 2) + 1) v = longint'(BIN_IN);
          else                           valid = 1'b0;
          vm    = v % 64'd100000000;
          d     = int'((vm / pow10(k)) % 10);
          blank = (k > 0) && (vm < pow10(k));
          exp_an  <= blank ? 8'hFF : ~one_hot;
          exp_cat <= blank ? 7'h7F : seg_tab[d];
        end else begin
          valid   = (a >= 2);
          exp_an  <= ~one_hot;
          exp_cat <= seg_tab[(BIN_IN >> (4 * k)) & 32'hF];
        end
        exp_valid <= valid;
        cur_digit <= int'(k);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en && exp_valid) begin
      checks++;
      if (ANODOS !== exp_an || CATODOS !== exp_cat) begin
        errors++;
        $display("FAIL scan digit %0d @%0t: got ANODOS=%b CATODOS=%b, expected ANODOS=%b CATODOS=%b",
                 cur_digit, $time, ANODOS, CATODOS, exp_an, exp_cat);
      end
    end
  end

  // Wait (bounded) for the model to be showing digit k with a defined
  // prediction. Then compare the DUT and the model against literals.
  task automatic expect_slot(input int k, input logic [7:0] an, input logic [6:0] cat,
                             input string name);
    int n = 0;
    @(negedge CLK);
    while (!(cur_digit == k && exp_valid) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s digit %0d: slot wait timed out after %0d cycles, required within 400", name, k, n);
    end else begin
      if (ANODOS !== an || CATODOS !== cat) begin
        errors++;
        $display("FAIL %s digit %0d: got ANODOS=%b CATODOS=%b, required ANODOS=%b CATODOS=%b",
                 name, k, ANODOS, CATODOS, an, cat);
      end
      checks++;
      if (exp_an !== an || exp_cat !== cat) begin
        errors++;
        $display("FAIL %s model digit %0d: model ANODOS=%b CATODOS=%b, required ANODOS=%b CATODOS=%b",
                 name, k, exp_an, exp_cat, an, cat);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (ANODOS !== 8'hFF || CATODOS !== 7'h7F) begin
      errors++;
      $display("FAIL %s: got ANODOS=%b CATODOS=%b, required ANODOS=11111111 CATODOS=1111111",
               name, ANODOS, CATODOS);
    end
  endtask

  // Hex mode: digit 7 is followed by digit 0; digit 0 lasts exactly 8
  // clocks; then digit 1 follows.
  task automatic scan_timing();
    int n = 0;
    int run = 0;
    while (ANODOS !== 8'h7F && n < 200) begin @(negedge CLK); n++; end
    while (ANODOS === 8'h7F && n < 200) begin @(negedge CLK); n++; end
    checks++;
    if (ANODOS !== 8'hFE) begin
      errors++;
      $display("FAIL scan wrap: got ANODOS=%b after digit 7, required 11111110", ANODOS);
    end
    while (ANODOS === 8'hFE && run < 100) begin @(negedge CLK); run++; end
    checks++;
    if (run != SLOT) begin
      errors++;
      $display("FAIL scan slot length: got %0d clocks, required %0d", run, SLOT);
    end
    checks++;
    if (ANODOS !== 8'hFD) begin
      errors++;
      $display("FAIL scan order: got ANODOS=%b after digit 0, required 11111101", ANODOS);
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1 check_reset_outputs("async reset mid-run");
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  logic [6:0] dec_ff [8] = '{7'h12, 7'h10, 7'h24, 7'h78, 7'h02, 7'h10, 7'h19, 7'h10};

  initial begin
    // Asynchronous reset with no clock running at all
    #1 RESET = 1'b0;
    #5 check_reset_outputs("reset before clock");
    BIN_IN      = 32'd99;
    DEC_TRIGGER = 1'b0;
    chk_en      = 1'b1;
    clk_en      = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;

    // Hex 99 = 0x63
    repeat (2 * 8 * SLOT) @(negedge CLK);
    expect_slot(0, 8'hFE, 7'b0110000, "hex 99");
    expect_slot(1, 8'hFD, 7'b0000010, "hex 99");
    for (int k = 2; k < 8; k++) expect_slot(k, ~(8'h01 << k), 7'b1000000, "hex 99");

    // Decimal 99
    #15 DEC_TRIGGER = 1'b1;
    repeat (2 * (N + 2)) @(negedge CLK);
    expect_slot(0, 8'hFE, 7'b0010000, "dec 99");
    expect_slot(1, 8'hFD, 7'b0010000, "dec 99");
    for (int k = 2; k < 8; k++) expect_slot(k, 8'hFF, 7'h7F, "dec 99 blank");

    // Decimal 0
    BIN_IN = '0;
    expect_slot(0, 8'hFE, 7'b1000000, "dec 0");
    for (int k = 1; k < 8; k++) expect_slot(k, 8'hFF, 7'h7F, "dec 0 blank");

    // All ones: decimal overflow and hex F
    BIN_IN = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) expect_slot(k, ~(8'h01 << k), dec_ff[k], "dec max");
    DEC_TRIGGER = 1'b0;
    for (int k = 0; k < 8; k++) expect_slot(k, ~(8'h01 << k), 7'b0001110, "hex max");

    scan_timing();

    // Reset in the middle of a conversion. Early decimal slots must show
    // the cleared result.
    DEC_TRIGGER = 1'b1;
    BIN_IN      = 32'd12345678;
    repeat (10) @(negedge CLK);
    pulse_reset();
    expect_slot(0, 8'hFE, 7'b1000000, "dec after reset");
    expect_slot(1, 8'hFF, 7'h7F, "dec after reset");

    // Randomised transactions
    for (int t = 0; t < 30; t++) begin
      int cat, hold, flip_at;
      cat = $urandom_range(0, 6);
      case (cat)
        0: BIN_IN = $urandom();
        1: BIN_IN = $urandom_range(0, 999);
        2: BIN_IN = '0;
        3: BIN_IN = ($urandom_range(0, 1) != 0) ? 32'd99999999 : 32'd100000000;
        4: BIN_IN = $urandom_range(0, 99999999);
        5: BIN_IN = 32'hFFFF_FFFF;
        default: BIN_IN = 32'd1 << $urandom_range(0, 31);
      endcase
      DEC_TRIGGER = 1'($urandom_range(0, 1));
      hold    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(100, 250);
      flip_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, hold) : -1;
      $display("txn %0d: BIN_IN=%0d (0x%08h) mode=%s hold=%0d", t, BIN_IN, BIN_IN,
               DEC_TRIGGER ? "dec" : "hex", hold);
      for (int c = 0; c < hold; c++) begin
        @(negedge CLK);
        if (c == flip_at) DEC_TRIGGER = ~DEC_TRIGGER;
      end
      if ($urandom_range(0, 7) == 0) pulse_reset();
    end

    repeat (20) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 2 ms");
    $fatal(1, "watchdog");
  end

endmodule
